// File: rtl/cap_pkg.sv
// Shared types and default sensor geometry for the frame capture controller.
package cap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    WAIT_SOF = 2'd2,
    CAPTURE  = 2'd3
  } cap_state_t;

  localparam int unsigned DEF_LINE_PIXELS = 640;
  localparam int unsigned DEF_FRAME_LINES = 480;
  localparam int unsigned DEF_DW          = 16;

endpackage

// File: rtl/cap_geom_check.sv
// Line-length and frame-height checker: counts gated pixels per line and lines
// per frame, raising sticky error flags that clear on an accepted start.
module cap_geom_check
  import cap_pkg::*;
#(
  parameter int unsigned LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int unsigned FRAME_LINES = DEF_FRAME_LINES
) (
  input  logic pclk,
  input  logic reset,
  input  logic clr,
  input  logic lv_q,
  input  logic lv_prev,
  input  logic line_end,
  input  logic fall,
  input  logic pass,
  output logic err_line,
  output logic err_frame
);

  localparam int unsigned PW = $clog2(2 * LINE_PIXELS + 1);
  localparam int unsigned LW = $clog2(2 * FRAME_LINES + 1);
  localparam logic [PW-1:0] PIX_EXP  = PW'(LINE_PIXELS);
  localparam logic [PW-1:0] PIX_MAX  = PW'(2 * LINE_PIXELS);
  localparam logic [LW-1:0] LINE_EXP = LW'(FRAME_LINES);
  localparam logic [LW-1:0] LINE_MAX = LW'(2 * FRAME_LINES);

  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic          err_line_q, err_line_d;
  logic          err_frame_q, err_frame_d;
  logic          eol;
  logic [LW-1:0] line_nxt;

  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    err_line_d  = err_line_q;
    err_frame_d = err_frame_q;
    // FV dropping while LV was still high closes the open line too
    eol      = line_end | (fall & lv_prev);
    line_nxt = line_cnt_q;

    if (eol) begin
      if (pass && (pix_cnt_q != PIX_EXP)) begin
        err_line_d = 1'b1;
      end
      pix_cnt_d = '0;
    end else if (lv_q && pass && (pix_cnt_q != PIX_MAX)) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    if (eol && pass && (line_cnt_q != LINE_MAX)) begin
      line_nxt = line_cnt_q + 1'b1;
    end

    // Height is judged on the count including a line closed by this same fall
    if (fall) begin
      if (pass && (line_nxt != LINE_EXP)) begin
        err_frame_d = 1'b1;
      end
      line_cnt_d = '0;
    end else begin
      line_cnt_d = line_nxt;
    end

    if (clr) begin
      pix_cnt_d   = '0;
      line_cnt_d  = '0;
      err_line_d  = 1'b0;
      err_frame_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
    end
  end

  assign err_line  = err_line_q;
  assign err_frame = err_frame_q;

endmodule

// File: rtl/cap_frame_ctrl.sv
// Frame-level capture controller: arms on command, gates the sensor stream to
// whole frames through a 2-stage pipeline, and counts completed frames.
module cap_frame_ctrl
  import cap_pkg::*;
#(
  parameter int unsigned LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int unsigned FRAME_LINES = DEF_FRAME_LINES,
  parameter int unsigned DW          = DEF_DW
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          FV,
  input  logic          LV,
  input  logic [DW-1:0] D_IN,
  input  logic          cmd_start,
  input  logic          cmd_stop,
  input  logic [7:0]    cfg_frames,
  output logic          FV_O,
  output logic          LV_O,
  output logic [DW-1:0] D_O,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    frames_captured,
  output logic          err_line,
  output logic          err_frame
);

  cap_state_t    state_q, state_d;
  logic          fv_q, lv_q;
  logic [DW-1:0] d_q;
  logic          fv_prev_q, lv_prev_q;
  logic          fv_o_q, lv_o_q;
  logic [DW-1:0] d_o_q;
  logic          stop_pend_q, stop_pend_d;
  logic [7:0]    cfg_q, cfg_d;
  logic [7:0]    frames_q, frames_d;
  logic          frame_done_q, frame_done_d;
  logic          clr;
  logic          rise, fall, line_end, pass;

  assign rise     = fv_q & ~fv_prev_q;
  assign fall     = ~fv_q & fv_prev_q;
  assign line_end = ~lv_q & lv_prev_q;
  // A stop coinciding with start-of-frame must not leak a one-cycle fragment
  assign pass     = (state_q == CAPTURE) |
                    ((state_q == WAIT_SOF) & rise & ~cmd_stop);

  always_comb begin
    state_d      = state_q;
    stop_pend_d  = stop_pend_q;
    cfg_d        = cfg_q;
    frames_d     = frames_q;
    frame_done_d = 1'b0;
    clr          = 1'b0;

    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (cmd_start && !cmd_stop) begin
          cfg_d    = cfg_frames;
          frames_d = '0;
          clr      = 1'b1;
          state_d  = ARM;
        end
      end
      ARM: begin
        if (cmd_stop) begin
          state_d = IDLE;
        end else if (!fv_q) begin
          state_d = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        if (cmd_stop) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (cmd_stop) begin
          stop_pend_d = 1'b1;
        end
        if (fall) begin
          frame_done_d = 1'b1;
          frames_d     = frames_q + 8'd1;
          if (stop_pend_q || cmd_stop ||
              ((cfg_q != 8'd0) && (frames_d == cfg_q))) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d = WAIT_SOF;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fv_q         <= 1'b0;
      lv_q         <= 1'b0;
      d_q          <= '0;
      fv_prev_q    <= 1'b0;
      lv_prev_q    <= 1'b0;
      fv_o_q       <= 1'b0;
      lv_o_q       <= 1'b0;
      d_o_q        <= '0;
      stop_pend_q  <= 1'b0;
      cfg_q        <= '0;
      frames_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fv_q         <= FV;
      lv_q         <= LV;
      d_q          <= D_IN;
      fv_prev_q    <= fv_q;
      lv_prev_q    <= lv_q;
      fv_o_q       <= fv_q & pass;
      lv_o_q       <= lv_q & pass;
      d_o_q        <= d_q;
      stop_pend_q  <= stop_pend_d;
      cfg_q        <= cfg_d;
      frames_q     <= frames_d;
      frame_done_q <= frame_done_d;
    end
  end

  cap_geom_check #(
    .LINE_PIXELS(LINE_PIXELS),
    .FRAME_LINES(FRAME_LINES)
  ) u_geom (
    .pclk     (pclk),
    .reset    (reset),
    .clr      (clr),
    .lv_q     (lv_q),
    .lv_prev  (lv_prev_q),
    .line_end (line_end),
    .fall     (fall),
    .pass     (pass),
    .err_line (err_line),
    .err_frame(err_frame)
  );

  assign FV_O            = fv_o_q;
  assign LV_O            = lv_o_q;
  assign D_O             = d_o_q;
  assign busy            = (state_q != IDLE);
  assign frame_done      = frame_done_q;
  assign frames_captured = frames_q;

endmodule

// File: tb/tb_cap_frame_ctrl.sv
// Scoreboard bench for cap_frame_ctrl using a reduced 16x6 sensor geometry.
module tb_cap_frame_ctrl;

  localparam int unsigned LP = 16;
  localparam int unsigned FL = 6;
  localparam int unsigned DW = 16;
  localparam int unsigned HB = 5;
  localparam int unsigned VB = 40;

  logic          pclk = 1'b0;
  logic          reset;
  logic          FV, LV;
  logic [DW-1:0] D_IN;
  logic          cmd_start, cmd_stop;
  logic [7:0]    cfg_frames;
  logic          FV_O, LV_O;
  logic [DW-1:0] D_O;
  logic          busy, frame_done;
  logic [7:0]    frames_captured;
  logic          err_line, err_frame;

  cap_frame_ctrl #(
    .LINE_PIXELS(LP),
    .FRAME_LINES(FL),
    .DW(DW)
  ) dut (
    .pclk(pclk), .reset(reset), .FV(FV), .LV(LV), .D_IN(D_IN),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cfg_frames(cfg_frames),
    .FV_O(FV_O), .LV_O(LV_O), .D_O(D_O), .busy(busy),
    .frame_done(frame_done), .frames_captured(frames_captured),
    .err_line(err_line), .err_frame(err_frame)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int            t;
    bit            lv;
    logic [DW-1:0] d;
  } pix_t;

  typedef struct {
    int t;
    int fc;
    bit busy;
  } fd_t;

  pix_t pix_q[$];
  fd_t  fd_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  int ev_start = -1;
  int ev_stop  = -1;
  int ev_reset = -1;
  int k_off    = 0;
  bit cap_now  = 1'b0;
  logic [DW-1:0] dcnt = 16'h1000;

  always @(posedge pclk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Monitor: pops expected pixels whenever FV_O is up, frame records on frame_done
  always @(negedge pclk) begin
    pix_t pe;
    fd_t  fe;
    if (FV_O === 1'b1) begin
      if (pix_q.size() == 0) begin
        chk("fv_o_unexpected", FV_O, 0);
      end else begin
        pe = pix_q.pop_front();
        chk("pix_cycle", cyc_n, pe.t);
        chk("lv_o", LV_O, pe.lv);
        chk("d_o", D_O, pe.d);
      end
    end else if (pix_q.size() > 0 && pix_q[0].t <= cyc_n) begin
      pe = pix_q.pop_front();
      chk("fv_o_missing", FV_O, 1);
    end

    if (frame_done === 1'b1) begin
      if (fd_q.size() == 0) begin
        chk("frame_done_unexpected", frame_done, 0);
      end else begin
        fe = fd_q.pop_front();
        chk("frame_done_cycle", cyc_n, fe.t);
        chk("frames_captured_at_done", frames_captured, fe.fc);
        chk("busy_at_done", busy, fe.busy);
      end
    end else if (fd_q.size() > 0 && fd_q[0].t <= cyc_n) begin
      fe = fd_q.pop_front();
      chk("frame_done_missing", frame_done, 1);
    end
  end

  task automatic step(input bit fv, input bit lv);
    pix_t pe;
    if (k_off == ev_start) cmd_start = 1'b1;
    if (k_off == ev_stop)  cmd_stop  = 1'b1;
    FV   = fv;
    LV   = lv;
    D_IN = dcnt;
    if (k_off == ev_reset) begin
      reset   = 1'b1;
      cap_now = 1'b0;
      while (pix_q.size() > 0 && pix_q[pix_q.size()-1].t >= cyc_n) void'(pix_q.pop_back());
      while (fd_q.size() > 0 && fd_q[fd_q.size()-1].t >= cyc_n) void'(fd_q.pop_back());
      #1;
      chk("reset_fv_o", FV_O, 0);
      chk("reset_lv_o", LV_O, 0);
      chk("reset_busy", busy, 0);
      chk("reset_frames", frames_captured, 0);
    end
    if (cap_now && fv) begin
      pe.t  = cyc_n + 2;
      pe.lv = lv;
      pe.d  = dcnt;
      pix_q.push_back(pe);
    end
    dcnt = dcnt + 16'h0B3D;
    @(posedge pclk);
    #1;
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    reset     = 1'b0;
    k_off++;
  endtask

  task automatic frame(input int lines, input int short_line, input bit cap,
                       input int fc_exp, input bit busy_exp);
    fd_t fe;
    k_off   = 0;
    cap_now = cap;
    repeat (3) step(1'b1, 1'b0);
    for (int ln = 0; ln < lines; ln++) begin
      int np;
      np = (ln == short_line) ? int'(LP) - 1 : int'(LP);
      for (int p = 0; p < np; p++) step(1'b1, 1'b1);
      repeat (HB) step(1'b1, 1'b0);
    end
    if (cap_now) begin
      fe.t    = cyc_n + 2;
      fe.fc   = fc_exp;
      fe.busy = busy_exp;
      fd_q.push_back(fe);
    end
    repeat (VB) step(1'b0, 1'b0);
    ev_start = -1;
    ev_stop  = -1;
    ev_reset = -1;
  endtask

  task automatic start_cmd(input logic [7:0] n);
    cfg_frames = n;
    cmd_start  = 1'b1;
    repeat (4) step(1'b0, 1'b0);
  endtask

  task automatic final_chk(input string tag, input int fc, input bit el, input bit ef);
    chk({tag, "_frames"}, frames_captured, fc);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_line"}, err_line, el);
    chk({tag, "_err_frame"}, err_frame, ef);
    chk({tag, "_pix_left"}, pix_q.size(), 0);
    chk({tag, "_done_left"}, fd_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc_n);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; FV = 1'b0; LV = 1'b0; D_IN = '0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cfg_frames = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_fv_o", FV_O, 0);
    chk("rst_lv_o", LV_O, 0);
    chk("rst_d_o", D_O, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frames", frames_captured, 0);
    chk("rst_err_line", err_line, 0);
    chk("rst_err_frame", err_frame, 0);
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0);

    // Single frame out of three
    start_cmd(8'd1);
    frame(FL, -1, 1'b1, 1, 1'b0);
    frame(FL, -1, 1'b0, 0, 1'b0);
    frame(FL, -1, 1'b0, 0, 1'b0);
    final_chk("single", 1, 1'b0, 1'b0);

    // Start while a frame is in flight: that frame is skipped
    cfg_frames = 8'd1;
    ev_start   = 50;
    frame(FL, -1, 1'b0, 0, 1'b0);
    frame(FL, -1, 1'b1, 1, 1'b0);
    final_chk("midframe", 1, 1'b0, 1'b0);

    // Geometry errors: short line, then short frame
    start_cmd(8'd2);
    frame(FL, 2, 1'b1, 1, 1'b1);
    chk("geom1_err_line", err_line, 1);
    chk("geom1_err_frame", err_frame, 0);
    chk("geom1_busy", busy, 1);
    frame(FL - 1, -1, 1'b1, 2, 1'b0);
    final_chk("geom2", 2, 1'b1, 1'b1);

    // Continuous mode, stop mid-line of the third frame
    start_cmd(8'd0);
    frame(FL, -1, 1'b1, 1, 1'b1);
    frame(FL, -1, 1'b1, 2, 1'b1);
    ev_stop = 3 + (LP + HB) * 2 + 5;
    frame(FL, -1, 1'b1, 3, 1'b0);
    frame(FL, -1, 1'b0, 0, 1'b0);
    final_chk("contstop", 3, 1'b0, 1'b0);

    // Reset mid-capture, then a frame without a new start
    start_cmd(8'd0);
    frame(FL, -1, 1'b1, 1, 1'b1);
    ev_reset = 40;
    frame(FL, -1, 1'b1, 0, 1'b0);
    frame(FL, -1, 1'b0, 0, 1'b0);
    final_chk("reset", 0, 1'b0, 1'b0);

    // Start+stop together, then stop while waiting for start-of-frame
    cfg_frames = 8'd1;
    cmd_start  = 1'b1;
    cmd_stop   = 1'b1;
    step(1'b0, 1'b0);
    chk("startstop_busy", busy, 0);
    cmd_start = 1'b1;
    step(1'b0, 1'b0);
    chk("arm_busy", busy, 1);
    step(1'b0, 1'b0);
    chk("wait_sof_busy", busy, 1);
    cmd_stop = 1'b1;
    step(1'b0, 1'b0);
    chk("stop_wait_busy", busy, 0);
    frame(FL, -1, 1'b0, 0, 1'b0);
    final_chk("stopwait", 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cap_frame_ctrl.md
# cap_frame_ctrl

Frame-level capture controller between the parallel camera pins (pclk, FV, LV, D_IN) and the capture core that converts pixels to AXI-Stream. It arms on a software command and starts capture only at a clean frame boundary. It gates FV/LV so the capture core only sees whole frames, captures a programmed number of frames (or runs continuously), and flags line-length and frame-height violations.

## Interface
- LINE_PIXELS, 640: expected LV-high cycles per line.
- FRAME_LINES, 480: expected lines per frame.
- DW, 16: pixel data width.
- pclk  in  1  pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- FV  in  1  sensor frame valid.
- LV  in  1  sensor line valid.
- D_IN  in  DW  sensor pixel data.
- cmd_start  in  1  one-cycle pulse; arm capture.
- cmd_stop  in  1  one-cycle pulse; request stop.
- cfg_frames  in  8  frames to capture; 0 = continuous. Sampled on accepted cmd_start.
- FV_O, LV_O, D_O  out  1/1/DW  gated, aligned stream to the capture core.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.
- frames_captured  out  8  frames completed since last start; wraps.
- err_line  out  1  sticky: a line length differed from LINE_PIXELS.
- err_frame  out  1  sticky: a frame line count differed from FRAME_LINES.

## Operation
- Stage 1 registers FV, LV and D_IN into fv_q, lv_q and d_q. fv_d and lv_d hold the previous fv_q and lv_q values. rise = fv_q & ~fv_d. fall = ~fv_q & fv_d. Line end = ~lv_q & lv_d.
- FSM states are IDLE, ARM, WAIT_SOF and CAPTURE.
  - IDLE: cmd_start (without cmd_stop) latches cfg_frames, clears frames_captured, err_line and err_frame, then goes to ARM.
  - ARM: goes to WAIT_SOF when fv_q = 0. This rejects a frame already in progress.
  - WAIT_SOF: goes to CAPTURE on rise.
  - CAPTURE: on fall, frame_done pulses, frames_captured increments and the line-count check runs. Next state is IDLE if stop is pending or if the target is non-zero and reached. Otherwise next state is WAIT_SOF.
- cmd_stop handling:
  - In ARM or WAIT_SOF: go to IDLE next cycle.
  - In CAPTURE: set stop_pend; the current frame completes.
  - In IDLE: ignored.
- cmd_start while busy is ignored. Simultaneous cmd_start and cmd_stop in IDLE: stop wins; remain IDLE.
- pass = (state == CAPTURE) | (state == WAIT_SOF & rise).
- Stage 2 registers: FV_O <= fv_q & pass; LV_O <= lv_q & pass; D_O <= d_q (ungated).
- pix_cnt: increments while lv_q & pass, saturating at 2*LINE_PIXELS. At line end, if pix_cnt != LINE_PIXELS, set err_line; then clear pix_cnt.
- line_cnt: increments on line end while in CAPTURE. FV falling while lv_d is high also counts as a line end. At fall, if line_cnt != FRAME_LINES, set err_frame; then clear line_cnt.
- Counter widths are $clog2(2*LINE_PIXELS+1) and $clog2(2*FRAME_LINES+1), both saturating.

## Timing
- Pin-to-FV_O/LV_O/D_O latency is exactly 2 pclk. Data stays aligned with valids.
- The first FV_O high cycle corresponds to the first FV high cycle of the captured frame. No partial frame is ever emitted.
- frame_done is asserted in the cycle after fall is seen, the same cycle FV_O first reads 0. frames_captured and the error flags update in that same cycle.
- busy drops in the same cycle as the final frame_done.
- Reset values (asynchronous, immediate): state IDLE; all outputs, counters, stop_pend and pipeline registers are 0.
- A reset mid-frame drops FV_O/LV_O at once. After reset, capture resumes only via a new cmd_start plus a fresh frame boundary.
- Errors stay set until the next accepted cmd_start.

## Structure
- cap_pkg holds the state enum cap_state_t (IDLE, ARM, WAIT_SOF, CAPTURE) and the default geometry localparams.
- One sub-module, cap_geom_check, contains pix_cnt, line_cnt and the err_line/err_frame logic. It is driven by lv_q, the edge strobes and pass.
- The FSM, the 2-stage pipeline and the frame counter live in cap_frame_ctrl.

## Test plan
- cfg_frames=1, FV low at start, three 640x480 frames with 120/200-cycle H porches and 120/100-line V porches:
  - Exactly the first frame appears on FV_O, with 480 LV_O pulses of 640 cycles each.
  - One frame_done; frames_captured=1; busy=0; no errors.
- cmd_start while FV is high mid-frame: FV_O stays 0 for that frame. The next frame passes with 2-cycle latency and D_O matches D_IN delayed by 2.
- cfg_frames=2, first frame has one 639-pixel line, second frame has 479 lines: err_line=1 and err_frame=1. Both frames still pass; frames_captured=2.
- cfg_frames=0, cmd_stop mid-line in frame 3: frame 3 completes fully and busy drops with the third frame_done. frames_captured=3.
- reset pulse mid-frame in CAPTURE: FV_O, LV_O and busy go to 0 immediately. A subsequent frame without cmd_start is not passed.
- cmd_start and cmd_stop in the same cycle in IDLE: busy stays 0. cmd_stop in WAIT_SOF: IDLE next cycle and FV_O never rises.
